softmax_job_sched: RTL and testbench
====================================

# softmax_job_sched

Multi-requester job scheduler for the single-lane fixed-point softmax core. Accepts softmax job descriptors (start/end address pairs) from up to NREQ requesters and arbitrates among them round-robin. For each job it sequences the core's init/start pulses, supervises its done stream with a watchdog, and reports per-job completion status. It sits between the requesting engines and the softmax core, and owns the core's init, start, address and soft-reset pins.

## Interface
- NREQ, 4, number of requesters (≥2)
- ADDRSIZE, 10, core address width
- TO_WIDTH, 16, watchdog counter width
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_valid  in  NREQ  per-requester job request
- req_ready  out  NREQ  one-hot grant/accept pulse
- req_start_addr  in  NREQ*ADDRSIZE  slice i belongs to requester i
- req_end_addr  in  NREQ*ADDRSIZE  slice i belongs to requester i
- timeout_cycles  in  TO_WIDTH  watchdog limit; 0 disables the watchdog
- sm_init  out  1  core init pulse
- sm_start  out  1  core start pulse
- sm_start_addr, sm_end_addr  out  ADDRSIZE  held for the whole job
- sm_done  in  1  core output-valid level
- sm_reset  out  1  core soft reset; integration ORs it with the global reset
- busy  out  1  high in any state except IDLE
- cmp_valid  out  1  completion pulse; no backpressure
- cmp_id  out  $clog2(NREQ)  requester of the completed job
- cmp_count  out  ADDRSIZE+1  observed sm_done beats
- cmp_error  out  1  reject, timeout or beat-count mismatch

## Operation
- FSM states: IDLE, INIT, START, WAIT_DONE, STREAM, RECOVER, CMPL. All outputs are registered and decoded from state.
- **IDLE:** if any req_valid is high, grant the first requester at or after rr_ptr.
  - req_ready[g]=1 for that cycle only; the descriptor is latched into sm_start_addr, sm_end_addr and cur_id.
  - rr_ptr <= g+1, wrapping modulo NREQ.
  - A requester must hold valid and its address slices stable until it sees ready.
- **Reject path:** if the latched end_addr ≤ start_addr, go to CMPL with cmp_error=1 and cmp_count=0. No sm_init or sm_start is issued.
- **Normal path:** otherwise go to INIT.
- **INIT:** sm_init=1 for one cycle, then START.
- **START:** sm_start=1 for one cycle, then WAIT_DONE. The timer is cleared on entry.
- **WAIT_DONE:** the timer increments each cycle. On sm_done=1, go to STREAM with beat count=1.
- **STREAM:** beat count increments on each cycle sm_done=1. The timer keeps running. On sm_done=0, go to CMPL.
- **Expected beats:** end_addr − start_addr. A mismatch sets cmp_error.
- **Watchdog:** if timeout_cycles≠0 and the timer equals timeout_cycles in WAIT_DONE or STREAM, go to RECOVER. Timeout takes priority over an sm_done edge in the same cycle.
- **RECOVER:** sm_reset=1 for exactly 2 cycles, then CMPL with cmp_error=1 and cmp_count equal to the beats seen so far.
- **CMPL:** cmp_valid=1 for one cycle with cmp_id, cmp_count and cmp_error, then IDLE.
- No new grant is made in the CMPL cycle; the earliest next grant is the following IDLE cycle.

## Timing
- **Reset:** state=IDLE, rr_ptr=0. All outputs are 0: req_ready, sm_init, sm_start, sm_reset, busy, cmp_valid, cmp_id, cmp_count, cmp_error, sm_start_addr, sm_end_addr.
- **Reset mid-job:** abandons the job with no completion pulse.
- **Latency:** grant at cycle T gives sm_init at T+1 and sm_start at T+2.
- **Completion:** cmp_valid is high in the cycle after the first sm_done=0 sample in STREAM. Reject gives cmp_valid at T+1.
- **Job period:** minimum from one grant to the next is 3 + wait + beats + 2 cycles.
- **sm_done while idle:** sm_done high in IDLE, INIT or START is ignored.
- **Address stability:** sm_start_addr and sm_end_addr change only on a grant.
- **Timer:** saturates at all-ones and does not wrap.
- **Arbitration fairness:** with all requesters valid, grant order is 0,1,2,3,0,…

## Test plan
- **Single job:** req0 with start=0, end=8; core model raises done 10 cycles after start for 8 cycles. Expect ready0 at T, init at T+1, start at T+2, and one cmp_valid with id=0, count=8, error=0.
- **Round-robin:** all four requesters valid continuously. Expect grants 0,1,2,3,0. Then drop req1 and verify 2,3,0,2 ordering resumes from rr_ptr.
- **Reject:** req2 with start=5, end=5. Expect cmp_valid at T+1 with id=2, count=0, error=1, and no init/start.
- **Timeout in wait:** timeout_cycles=20, core never raises done. Expect RECOVER with sm_reset high for 2 cycles, then cmp error=1, count=0, and busy dropping one cycle after cmp_valid.
- **Count mismatch:** start=0, end=4, core gives 3 done beats. Expect count=3, error=1. Also run timeout_cycles=0 with a 70000-cycle wait and expect no timeout.
- **Mid-job reset:** reset asserted in STREAM. Expect all outputs 0 the next cycle, no cmp_valid, and the next grant to requester 0.

Source files
------------

// File: rtl/softmax_job_sched.sv
// softmax_job_sched: round-robin job scheduler in front of the single-lane
// softmax core. It grants one requester at a time and sequences the core's
// init/start pulses. It counts the core's done beats, runs a watchdog that can
// soft-reset the core, and reports one completion record per job.
//
// Handshakes:
//   req_valid[i]/req_ready[i]: requester i raises valid and holds valid plus
//   its address slices stable until it sees ready. ready is a one-cycle pulse,
//   and the descriptor transfers in that cycle. At most one ready bit is high
//   at a time.
//   cmp_valid: one-cycle completion pulse carrying cmp_id/cmp_count/cmp_error.
//   It has no backpressure.
module softmax_job_sched #(
  parameter int NREQ     = 4,
  parameter int ADDRSIZE = 10,
  parameter int TO_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*ADDRSIZE-1:0] req_start_addr,
  input  logic [NREQ*ADDRSIZE-1:0] req_end_addr,
  input  logic [TO_WIDTH-1:0]      timeout_cycles,
  output logic                     sm_init,
  output logic                     sm_start,
  output logic [ADDRSIZE-1:0]      sm_start_addr,
  output logic [ADDRSIZE-1:0]      sm_end_addr,
  input  logic                     sm_done,
  output logic                     sm_reset,
  output logic                     busy,
  output logic                     cmp_valid,
  output logic [$clog2(NREQ)-1:0]  cmp_id,
  output logic [ADDRSIZE:0]        cmp_count,
  output logic                     cmp_error,
  output logic [2:0]               dbg_state_o
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INIT      = 3'd1,
    S_START     = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_STREAM    = 3'd4,
    S_RECOVER   = 3'd5,
    S_CMPL      = 3'd6
  } state_e;

  state_e                state_q, state_d;
  logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]        cur_id_q, cur_id_d;
  logic [ADDRSIZE-1:0]   start_addr_q, start_addr_d;
  logic [ADDRSIZE-1:0]   end_addr_q, end_addr_d;
  logic [TO_WIDTH-1:0]   timer_q, timer_d;
  logic [ADDRSIZE:0]     beats_q, beats_d;
  logic                  err_q, err_d;
  logic                  rec_q, rec_d;
  logic [NREQ-1:0]       req_ready_q, grant_d;

  logic                  init_q, start_q, sm_reset_q, busy_q;
  logic                  cmp_valid_q, cmp_error_q;
  logic [IDW-1:0]        cmp_id_q;
  logic [ADDRSIZE:0]     cmp_count_q;

  logic                  arb_en;
  logic                  arb_found;
  logic [IDW-1:0]        arb_g;
  logic [IDW-1:0]        cand;
  int                    arb_base;
  logic                  wd_fire;
  logic [ADDRSIZE:0]     exp_beats;
  logic [TO_WIDTH-1:0]   timer_inc;
  logic [ADDRSIZE:0]     beats_inc;

  // Requester index base+off, wrapped modulo NREQ.
  function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return s[IDW-1:0];
  endfunction

  assign exp_beats = {1'b0, end_addr_q} - {1'b0, start_addr_q};
  assign timer_inc = (&timer_q) ? timer_q : timer_q + 1'b1;
  assign beats_inc = (&beats_q) ? beats_q : beats_q + 1'b1;
  assign wd_fire   = (timeout_cycles != '0) && (timer_q == timeout_cycles);

  // Next-state logic, job bookkeeping and round-robin arbitration.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    cur_id_d     = cur_id_q;
    start_addr_d = start_addr_q;
    end_addr_d   = end_addr_q;
    timer_d      = timer_q;
    beats_d      = beats_q;
    err_d        = err_q;
    rec_d        = rec_q;
    grant_d      = '0;
    arb_en       = 1'b0;
    arb_found    = 1'b0;
    arb_g        = '0;
    cand         = '0;
    arb_base     = 0;

    case (state_q)
      S_IDLE: begin
        // A ready pulse is out this cycle: the descriptor is already latched,
        // so decide between the reject and normal paths instead of granting.
        if (req_ready_q != '0) begin
          beats_d = '0;
          if (end_addr_q <= start_addr_q) begin
            err_d   = 1'b1;
            state_d = S_CMPL;
          end else begin
            err_d   = 1'b0;
            state_d = S_INIT;
          end
        end else begin
          arb_en = 1'b1;
        end
      end
      S_INIT: begin
        timer_d = '0;
        state_d = S_START;
      end
      S_START: begin
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (wd_fire) begin
          err_d   = 1'b1;
          rec_d   = 1'b0;
          state_d = S_RECOVER;
        end else begin
          timer_d = timer_inc;
          if (sm_done) begin
            beats_d = {{ADDRSIZE{1'b0}}, 1'b1};
            state_d = S_STREAM;
          end
        end
      end
      S_STREAM: begin
        if (wd_fire) begin
          err_d   = 1'b1;
          rec_d   = 1'b0;
          state_d = S_RECOVER;
        end else begin
          timer_d = timer_inc;
          if (sm_done) begin
            beats_d = beats_inc;
          end else begin
            if (beats_q != exp_beats) err_d = 1'b1;
            state_d = S_CMPL;
          end
        end
      end
      S_RECOVER: begin
        // Two cycles of core soft reset, tracked by rec_q.
        if (rec_q) state_d = S_CMPL;
        else       rec_d   = 1'b1;
      end
      S_CMPL: begin
        // The grant decided here shows up in the following IDLE cycle.
        arb_en  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (arb_en) begin
      for (int k = 0; k < NREQ; k++) begin
        cand = rr_index(rr_ptr_q, k);
        if (!arb_found && req_valid[cand]) begin
          arb_found = 1'b1;
          arb_g     = cand;
        end
      end
      if (arb_found) begin
        arb_base       = int'(arb_g) * ADDRSIZE;
        grant_d[arb_g] = 1'b1;
        rr_ptr_d       = rr_index(arb_g, 1);
        cur_id_d       = arb_g;
        start_addr_d   = req_start_addr[arb_base +: ADDRSIZE];
        end_addr_d     = req_end_addr[arb_base +: ADDRSIZE];
      end
    end
  end

  // State, datapath and registered output decodes of the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      cur_id_q     <= '0;
      start_addr_q <= '0;
      end_addr_q   <= '0;
      timer_q      <= '0;
      beats_q      <= '0;
      err_q        <= 1'b0;
      rec_q        <= 1'b0;
      req_ready_q  <= '0;
      init_q       <= 1'b0;
      start_q      <= 1'b0;
      sm_reset_q   <= 1'b0;
      busy_q       <= 1'b0;
      cmp_valid_q  <= 1'b0;
      cmp_id_q     <= '0;
      cmp_count_q  <= '0;
      cmp_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      cur_id_q     <= cur_id_d;
      start_addr_q <= start_addr_d;
      end_addr_q   <= end_addr_d;
      timer_q      <= timer_d;
      beats_q      <= beats_d;
      err_q        <= err_d;
      rec_q        <= rec_d;
      req_ready_q  <= grant_d;
      init_q       <= (state_d == S_INIT);
      start_q      <= (state_d == S_START);
      sm_reset_q   <= (state_d == S_RECOVER);
      busy_q       <= (state_d != S_IDLE);
      cmp_valid_q  <= (state_d == S_CMPL);
      cmp_id_q     <= (state_d == S_CMPL) ? cur_id_q : '0;
      cmp_count_q  <= (state_d == S_CMPL) ? beats_d : '0;
      cmp_error_q  <= (state_d == S_CMPL) ? err_d : 1'b0;
    end
  end

  assign req_ready     = req_ready_q;
  assign sm_init       = init_q;
  assign sm_start      = start_q;
  assign sm_start_addr = start_addr_q;
  assign sm_end_addr   = end_addr_q;
  assign sm_reset      = sm_reset_q;
  assign busy          = busy_q;
  assign cmp_valid     = cmp_valid_q;
  assign cmp_id        = cmp_id_q;
  assign cmp_count     = cmp_count_q;
  assign cmp_error     = cmp_error_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_softmax_job_sched.sv
// Testbench for softmax_job_sched: table-driven jobs plus hand-written
// sequences for round-robin, watchdog, idle done and mid-job reset.
module tb_softmax_job_sched;

  localparam int NREQ     = 4;
  localparam int ADDRSIZE = 10;
  localparam int TO_WIDTH = 16;
  localparam int IDW      = 2;
  localparam int CW       = ADDRSIZE + 1;
  localparam int W        = IDW + CW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0]          req_ready;
  logic [NREQ*ADDRSIZE-1:0] req_start_addr;
  logic [NREQ*ADDRSIZE-1:0] req_end_addr;
  logic [TO_WIDTH-1:0]      timeout_cycles;
  logic                     sm_init, sm_start, sm_reset, sm_done, busy;
  logic [ADDRSIZE-1:0]      sm_start_addr, sm_end_addr;
  logic                     cmp_valid, cmp_error;
  logic [IDW-1:0]           cmp_id;
  logic [CW-1:0]            cmp_count;
  logic [2:0]               dbg_state;

  softmax_job_sched #(.NREQ(NREQ), .ADDRSIZE(ADDRSIZE), .TO_WIDTH(TO_WIDTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_start_addr(req_start_addr),
    .req_end_addr  (req_end_addr),
    .timeout_cycles(timeout_cycles),
    .sm_init       (sm_init),
    .sm_start      (sm_start),
    .sm_start_addr (sm_start_addr),
    .sm_end_addr   (sm_end_addr),
    .sm_done       (sm_done),
    .sm_reset      (sm_reset),
    .busy          (busy),
    .cmp_valid     (cmp_valid),
    .cmp_id        (cmp_id),
    .cmp_count     (cmp_count),
    .cmp_error     (cmp_error),
    .dbg_state_o   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [IDW-1:0]      id;
    logic [ADDRSIZE-1:0] s;
    logic [ADDRSIZE-1:0] e;
    int                  wait_cyc;
    int                  beats;
    logic [CW-1:0]       exp_count;
    logic                exp_err;
  } job_t;

  job_t tbl [8];
  logic [IDW-1:0] rr_exp [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pops one expected completion per cmp_valid pulse.
  task automatic sb_monitor();
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (!reset && cmp_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL cmp_unexpected: id=%0d count=%0d error=%0b, expected no completion",
                   cmp_id, cmp_count, cmp_error);
        end else begin
          e = exp_q.pop_front();
          check("cmp_result{id,count,err}", 32'({cmp_id, cmp_count, cmp_error}), 32'(e));
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_desc(input int id, input logic [ADDRSIZE-1:0] s, input logic [ADDRSIZE-1:0] e);
    req_start_addr[id*ADDRSIZE +: ADDRSIZE] = s;
    req_end_addr[id*ADDRSIZE +: ADDRSIZE]   = e;
  endtask

  task automatic wait_grant(input string name, input logic [NREQ-1:0] exp_ready);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready == '0 && n < 50);
    check(name, 32'(req_ready), 32'(exp_ready));
  endtask

  task automatic wait_start(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sm_start && n < 20);
    check(name, 32'(sm_start), 32'd1);
  endtask

  // One job from request to completion, with a simple core done-stream model.
  task automatic run_job(input job_t v);
    logic rej;
    rej = (v.e <= v.s);
    exp_q.push_back({v.id, v.exp_count, v.exp_err});
    set_desc(int'(v.id), v.s, v.e);
    req_valid[v.id] = 1'b1;
    wait_grant("grant_onehot", 4'b0001 << v.id);
    req_valid[v.id] = 1'b0;
    @(negedge clk);  // T+1
    check("init_at_t1", 32'(sm_init), 32'(!rej));
    check("busy_at_t1", 32'(busy), 32'd1);
    check("addr_latch", 32'({sm_start_addr, sm_end_addr}), 32'({v.s, v.e}));
    if (rej) check("reject_cmp_at_t1", 32'(cmp_valid), 32'd1);
    @(negedge clk);  // T+2
    check("start_at_t2", 32'(sm_start), 32'(!rej));
    if (!rej) begin
      repeat (v.wait_cyc) @(negedge clk);
      sm_done = 1'b1;
      repeat (v.beats) @(negedge clk);
      sm_done = 1'b0;
      @(negedge clk);
      check("cmp_latency", 32'(cmp_valid), 32'd1);
      @(negedge clk);
    end
    check("busy_after_cmp", 32'(busy), 32'd0);
  endtask

  // ---------------- safety net ----------------
  initial begin
    #1500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int cs;

    //              id    start     end      wait beats count    err
    tbl[0] = '{2'd0, 10'd0,    10'd8,    10, 8, 11'd8, 1'b0};
    tbl[1] = '{2'd1, 10'd16,   10'd20,   3,  4, 11'd4, 1'b0};
    tbl[2] = '{2'd2, 10'd5,    10'd5,    0,  0, 11'd0, 1'b1};
    tbl[3] = '{2'd0, 10'd1020, 10'd1023, 1,  3, 11'd3, 1'b0};
    tbl[4] = '{2'd2, 10'd100,  10'd99,   0,  0, 11'd0, 1'b1};
    tbl[5] = '{2'd1, 10'd0,    10'd1,    1,  1, 11'd1, 1'b0};
    tbl[6] = '{2'd3, 10'd0,    10'd4,    2,  3, 11'd3, 1'b1};
    tbl[7] = '{2'd3, 10'd10,   10'd12,   5,  5, 11'd5, 1'b1};
    rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd3, 2'd0, 2'd2};

    reset          = 1'b1;
    req_valid      = '0;
    req_start_addr = '0;
    req_end_addr   = '0;
    sm_done        = 1'b0;
    timeout_cycles = 16'd1000;

    fork
      sb_monitor();
    join_none

    repeat (3) @(negedge clk);
    check("reset_ctrl", 32'({req_ready, sm_init, sm_start, sm_reset, busy, cmp_valid, cmp_error, cmp_id}), 32'd0);
    check("reset_data", 32'({sm_start_addr, sm_end_addr, cmp_count}), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Table-driven jobs: normal, reject and beat-count mismatch.
    for (int i = 0; i < 8; i++) run_job(tbl[i]);

    // sm_done while idle must be ignored.
    sm_done = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_done_busy", 32'(busy), 32'd0);
    check("idle_done_state", 32'(dbg_state), 32'd0);
    sm_done = 1'b0;
    @(negedge clk);

    // Round-robin with every requester valid, then requester 1 dropped.
    for (int i = 0; i < NREQ; i++) set_desc(i, 10'(20 + i), 10'(i));
    req_valid = 4'b1111;
    for (int k = 0; k < 9; k++) begin
      exp_q.push_back({rr_exp[k], 11'd0, 1'b1});
      wait_grant("rr_grant", 4'b0001 << rr_exp[k]);
      if (k == 4) req_valid = 4'b1101;
    end
    req_valid = '0;
    repeat (3) @(negedge clk);
    check("rr_drain", 32'(exp_q.size()), 32'd0);

    // Watchdog timeout while waiting for done.
    timeout_cycles = 16'd20;
    set_desc(0, 10'd0, 10'd8);
    exp_q.push_back({2'd0, 11'd0, 1'b1});
    req_valid[0] = 1'b1;
    wait_grant("to_grant", 4'b0001);
    req_valid[0] = 1'b0;
    wait_start("to_start");
    cs = cyc;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sm_reset && n < 60);
    check("to_reset_delay", 32'(cyc - cs), 32'd22);
    @(negedge clk);
    check("to_reset_2nd", 32'(sm_reset), 32'd1);
    check("to_no_early_cmp", 32'(cmp_valid), 32'd0);
    @(negedge clk);
    check("to_reset_off", 32'(sm_reset), 32'd0);
    check("to_cmp", 32'(cmp_valid), 32'd1);
    @(negedge clk);
    check("to_busy_drop", 32'(busy), 32'd0);

    // Watchdog disabled: a very long wait must not time out.
    timeout_cycles = 16'd0;
    run_job('{2'd1, 10'd0, 10'd2, 70000, 2, 11'd2, 1'b0});

    // Reset in STREAM: job abandoned, arbitration restarts at requester 0.
    set_desc(0, 10'd0, 10'd8);
    req_valid[0] = 1'b1;
    wait_grant("mr_grant", 4'b0001);
    req_valid[0] = 1'b0;
    wait_start("mr_start");
    repeat (2) @(negedge clk);
    sm_done = 1'b1;
    repeat (3) @(negedge clk);
    check("mr_in_stream", 32'(dbg_state), 32'd4);
    reset = 1'b1;
    @(negedge clk);
    check("mr_ctrl_zero", 32'({req_ready, sm_init, sm_start, sm_reset, busy, cmp_valid, cmp_error, cmp_id}), 32'd0);
    check("mr_data_zero", 32'({sm_start_addr, sm_end_addr, cmp_count}), 32'd0);
    check("mr_state", 32'(dbg_state), 32'd0);
    reset   = 1'b0;
    sm_done = 1'b0;
    set_desc(0, 10'd3, 10'd1);
    set_desc(1, 10'd7, 10'd2);
    exp_q.push_back({2'd0, 11'd0, 1'b1});
    exp_q.push_back({2'd1, 11'd0, 1'b1});
    req_valid = 4'b0011;
    wait_grant("mr_next_grant0", 4'b0001);
    req_valid[0] = 1'b0;
    wait_grant("mr_next_grant1", 4'b0010);
    req_valid[1] = 1'b0;
    repeat (3) @(negedge clk);
    check("final_drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
